conv_layer_ctrl: RTL and testbench
==================================

Name: conv_layer_ctrl

Overview:
- Sequences one convolution layer across NUM_CH parallel 5x5 conv engines that share a single weight FIFO and a single tap stream.
- Waits for a full weight set, raises all engine starts together, and feeds weights channel by channel (25 pops per channel).
- Enables the pixel/tap streamer once weights are in, collects each engine's done pulse, and reports layer completion or timeout to the top-level layer sequencer.

Parameters:
- NUM_CH, 6, number of conv engines sharing the weight FIFO.
- WLEN, 25, weights per engine (K*K, K=5).
- LVL_W, 8, width of the weight FIFO fill-level input.
- TMO, 1023, maximum RUN cycles before the timeout error is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- layer_go  in  1  one-cycle request to start a layer; ignored while busy.
- layer_sel  in  1  0 = 28x28 input, 1 = 12x12 input.
- wfifo_level  in  LVL_W  weight FIFO occupancy (show-ahead FIFO: data valid on the same cycle as rd).
- wfifo_rd  out  1  weight FIFO pop.
- conv_weight_en  out  NUM_CH  per-engine weight-capture enable.
- conv_start  out  NUM_CH  per-engine start; held high for the whole layer.
- conv_state  out  1  registered copy of layer_sel, forwarded to the engines.
- conv_done  in  NUM_CH  per-engine one-cycle completion pulses.
- pix_en  out  1  enables the tap/line-buffer streamer.
- busy  out  1  high in any state other than IDLE.
- layer_done  out  1  one-cycle pulse on layer completion.
- err_tmo  out  1  sticky timeout flag; cleared by the next accepted layer_go.

Behaviour:
- Reset: every output is 0, state = IDLE, all counters and done latches are 0. Reset asserted mid-layer aborts at once; the engines then see start=0 and clear themselves.
- IDLE:
  - layer_go=1: latch layer_sel into conv_state, clear err_tmo and the done latches, go to WAIT_W.
  - layer_go seen in any other state is dropped.
- WAIT_W: stay until wfifo_level >= NUM_CH*WLEN (150). Then go to LOAD and assert all conv_start bits in that same cycle. Engine timing is fixed once start rises, so the weight load must never stall.
- LOAD, exactly NUM_CH*WLEN cycles:
  - Counters ch (0..NUM_CH-1) and wcnt (0..WLEN-1); each cycle wfifo_rd=1 and conv_weight_en = one-hot(ch).
  - wcnt wraps 24->0 and increments ch. Weights are row-major per engine, engine 0 first.
  - An engine that is started but not yet enabled holds its k00 slot, which is overwritten correctly on its first enabled cycle; this is legal.
  - After the last pop (ch=NUM_CH-1, wcnt=WLEN-1): weight_en=0, wfifo_rd=0, pix_en=1 on the next cycle, go to RUN.
  - So pix_en rises on start-relative cycle 150 (start rising = cycle 0).
- RUN:
  - conv_start and pix_en held high. conv_done[i] is OR-ed into sticky done_lat[i]. A done pulse arriving on the same cycle as entry to RUN is still latched.
  - done_lat all ones: go to FINISH.
  - RUN cycle counter reaches TMO first: set err_tmo and go to FINISH.
- FINISH, one cycle: conv_start=0, pix_en=0, layer_done=1, then IDLE. The engines therefore see start low for at least 2 cycles before any next layer.
- busy = (state != IDLE). layer_done is registered.
- Simultaneous events:
  - Timeout and the final done on the same cycle: completion wins, err_tmo stays 0.
  - conv_done arriving in LOAD/WAIT_W is latched too, but a layer cannot complete before RUN.
- Widths: wcnt 5 bits, ch clog2(NUM_CH) bits, RUN counter clog2(TMO+1) bits. The level compare is unsigned.

Decomposition:
- Shared package (cnn_pkg):
  - State enum IDLE/WAIT_W/LOAD/RUN/FINISH.
  - Constants KSIZE=5, WLEN=KSIZE*KSIZE, NUM_CH=6, FMAP_28=28, FMAP_12=12.
- One natural sub-module: wload_seq, the ch/wcnt counter and one-hot weight_en generator with a last-pop flag. FSM, done collection and timeout stay in the top.

Test Plan:
- Reset mid-LOAD (rst at start-relative cycle 40) -> all outputs 0 on the same cycle; state IDLE; next layer_go restarts cleanly from ch=0.
- wfifo_level=149, then layer_go -> stays in WAIT_W, no wfifo_rd. Level goes to 150 -> conv_start=6'h3F and first pop that cycle. Exactly 150 pops; weight_en goes 6'h01 for 25 cycles, then 6'h02 for 25 cycles, ... through 6'h20.
- Full 28x28 layer with model engines pulsing done at start-relative cycle 829, staggered 0..5 cycles across engines -> pix_en high from cycle 150; layer_done one cycle after the last done; busy low afterwards.
- layer_sel=1 with layer_go; layer_sel changed to 0 mid-layer -> conv_state stays 1 for the whole layer.
- Engine 3 never pulses done, TMO=1023 -> err_tmo=1 at RUN cycle 1023, layer_done pulses, err_tmo stays 1 until the next layer_go.
- layer_go pulsed during RUN -> ignored, no restart. A second layer_go one cycle after layer_done -> accepted; conv_start was low for at least 2 cycles in between.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and layer-sequencer state type for the conv layer datapath.
package cnn_pkg;

  localparam int unsigned KSIZE   = 5;
  localparam int unsigned WLEN    = KSIZE * KSIZE;
  localparam int unsigned NUM_CH  = 6;
  localparam int unsigned FMAP_28 = 28;
  localparam int unsigned FMAP_12 = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    LOAD,
    RUN,
    FINISH
  } layer_state_e;

endpackage

// File: rtl/conv_layer_ctrl_wload_seq.sv
// Weight-load sequencer: walks engine/weight counters while step_i is high and
// decodes the one-hot per-engine capture enable plus a last-pop flag.
module wload_seq #(
  parameter int unsigned NUM_CH = cnn_pkg::NUM_CH,
  parameter int unsigned WLEN   = cnn_pkg::WLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  output logic [NUM_CH-1:0] weight_en_o,
  output logic              last_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] ch_q, ch_d;
  logic [4:0]      wcnt_q, wcnt_d;
  logic            at_end;

  assign at_end = (ch_q == CH_W'(NUM_CH - 1)) && (wcnt_q == 5'(WLEN - 1));
  assign last_o = step_i && at_end;

  // Counters wrap back to zero after the final pop, so the next load starts clean.
  always_comb begin
    ch_d   = ch_q;
    wcnt_d = wcnt_q;
    if (step_i) begin
      if (wcnt_q == 5'(WLEN - 1)) begin
        wcnt_d = '0;
        ch_d   = at_end ? '0 : ch_q + CH_W'(1);
      end else begin
        wcnt_d = wcnt_q + 5'd1;
      end
    end
  end

  always_comb begin
    weight_en_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      weight_en_o[i] = step_i && (ch_q == CH_W'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_q   <= '0;
      wcnt_q <= '0;
    end else begin
      ch_q   <= ch_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer for NUM_CH parallel 5x5 conv engines: weight-set wait,
// non-stalling weight broadcast, done collection and RUN timeout.
module conv_layer_ctrl #(
  parameter int unsigned NUM_CH = cnn_pkg::NUM_CH,
  parameter int unsigned WLEN   = cnn_pkg::WLEN,
  parameter int unsigned LVL_W  = 8,
  parameter int unsigned TMO    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_go,
  input  logic              layer_sel,
  input  logic [LVL_W-1:0]  wfifo_level,
  output logic              wfifo_rd,
  output logic [NUM_CH-1:0] conv_weight_en,
  output logic [NUM_CH-1:0] conv_start,
  output logic              conv_state,
  input  logic [NUM_CH-1:0] conv_done,
  output logic              pix_en,
  output logic              busy,
  output logic              layer_done,
  output logic              err_tmo
);

  import cnn_pkg::*;

  localparam int unsigned     RUN_W    = $clog2(TMO + 1);
  localparam logic [LVL_W-1:0] FULL_SET = LVL_W'(NUM_CH * WLEN);

  layer_state_e      state_q;
  logic [NUM_CH-1:0] conv_start_q;
  logic              conv_state_q;
  logic              pix_en_q;
  logic              layer_done_q;
  logic              err_tmo_q;
  logic [NUM_CH-1:0] done_lat_q;
  logic [RUN_W-1:0]  run_q;

  logic              load_active;
  logic              wl_last;
  logic [NUM_CH-1:0] done_nxt;

  assign load_active = (state_q == LOAD);
  assign done_nxt    = done_lat_q | conv_done;

  wload_seq #(
    .NUM_CH (NUM_CH),
    .WLEN   (WLEN)
  ) u_wload (
    .clk_i       (clk),
    .rst_i       (rst),
    .step_i      (load_active),
    .weight_en_o (conv_weight_en),
    .last_o      (wl_last)
  );

  assign wfifo_rd   = load_active;
  assign busy       = (state_q != IDLE);
  assign conv_start = conv_start_q;
  assign conv_state = conv_state_q;
  assign pix_en     = pix_en_q;
  assign layer_done = layer_done_q;
  assign err_tmo    = err_tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      conv_start_q <= '0;
      conv_state_q <= 1'b0;
      pix_en_q     <= 1'b0;
      layer_done_q <= 1'b0;
      err_tmo_q    <= 1'b0;
      done_lat_q   <= '0;
      run_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (layer_go) begin
            conv_state_q <= layer_sel;
            err_tmo_q    <= 1'b0;
            done_lat_q   <= '0;
            state_q      <= WAIT_W;
          end
        end
        WAIT_W: begin
          done_lat_q <= done_nxt;
          if (wfifo_level >= FULL_SET) begin
            conv_start_q <= '1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          done_lat_q <= done_nxt;
          if (wl_last) begin
            pix_en_q <= 1'b1;
            run_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          done_lat_q <= done_nxt;
          run_q      <= run_q + RUN_W'(1);
          // Completion is tested first so a final done on the timeout cycle wins.
          if (&done_nxt) begin
            conv_start_q <= '0;
            pix_en_q     <= 1'b0;
            layer_done_q <= 1'b1;
            state_q      <= FINISH;
          end else if (run_q == RUN_W'(TMO - 1)) begin
            err_tmo_q    <= 1'b1;
            conv_start_q <= '0;
            pix_en_q     <= 1'b0;
            layer_done_q <= 1'b1;
            state_q      <= FINISH;
          end
        end
        FINISH: begin
          layer_done_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl against a start-relative timeline model.
module tb_conv_layer_ctrl;

  localparam int NCH   = 6;
  localparam int NW    = 150;
  localparam int TMO_C = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic       layer_go;
  logic       layer_sel;
  logic [7:0] wfifo_level;
  logic       wfifo_rd;
  logic [5:0] conv_weight_en;
  logic [5:0] conv_start;
  logic       conv_state;
  logic [5:0] conv_done;
  logic       pix_en;
  logic       busy;
  logic       layer_done;
  logic       err_tmo;

  conv_layer_ctrl #(
    .NUM_CH (NCH),
    .WLEN   (25),
    .LVL_W  (8),
    .TMO    (TMO_C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .layer_go       (layer_go),
    .layer_sel      (layer_sel),
    .wfifo_level    (wfifo_level),
    .wfifo_rd       (wfifo_rd),
    .conv_weight_en (conv_weight_en),
    .conv_start     (conv_start),
    .conv_state     (conv_state),
    .conv_done      (conv_done),
    .pix_en         (pix_en),
    .busy           (busy),
    .layer_done     (layer_done),
    .err_tmo        (err_tmo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 awaiting weights, 2 started (m_k = cycles since start), 3 finishing.
  int         m_phase;
  int         m_k;
  logic [5:0] m_mask;
  logic       m_err;
  logic       m_sel;
  int         done_t[NCH];
  int         pops;
  int         gap;
  bit         seen_start;

  task automatic model_reset();
    m_phase = 0;
    m_k     = 0;
    m_mask  = '0;
    m_err   = 1'b0;
    m_sel   = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (layer_go) begin
             m_phase = 1; m_sel = layer_sel; m_err = 1'b0; m_mask = '0;
           end
        1: begin
             m_mask |= conv_done;
             if (int'(wfifo_level) >= NW) begin m_phase = 2; m_k = 0; end
           end
        2: begin
             if (m_k >= NW) begin
               if ((m_mask | conv_done) == 6'h3F) m_phase = 3;
               else if (m_k - NW + 1 == TMO_C) begin m_err = 1'b1; m_phase = 3; end
               else m_k++;
             end else begin
               m_k++;
             end
             m_mask |= conv_done;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic logic [17:0] exp_outs();
    logic       st, rd, pix;
    logic [5:0] wen;
    st  = (m_phase == 2);
    rd  = st && (m_k < NW);
    wen = rd ? 6'(1 << (m_k / 25)) : 6'h00;
    pix = st && (m_k >= NW);
    return {m_phase != 0, {6{st}}, rd, wen, pix, m_phase == 3, m_err, m_sel};
  endfunction

  function automatic logic [17:0] dut_outs();
    return {busy, conv_start, wfifo_rd, conv_weight_en, pix_en, layer_done, err_tmo, conv_state};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("outs", 32'(dut_outs()), 32'(exp_outs()));
    if (wfifo_rd) pops++;
    if (conv_start == '0) gap++;
    else begin
      if (gap > 0 && seen_start) chk("start_gap", 32'(gap >= 2), 32'd1);
      seen_start = 1'b1;
      gap = 0;
    end
    for (int i = 0; i < NCH; i++) conv_done[i] = (m_phase == 2) && (m_k == done_t[i]);
  endtask

  task automatic run_layer(input logic sel, input int low, input bit inject);
    int n;
    pops        = 0;
    wfifo_level = 8'd149;
    layer_sel   = sel;
    layer_go    = 1'b1;
    cyc();
    layer_go = 1'b0;
    repeat (low) cyc();
    wfifo_level = (low > 0) ? 8'd150 : 8'($urandom_range(150, 255));
    n = 0;
    while (m_phase != 0 && n < 3000) begin
      if (inject) begin
        layer_sel = 1'($urandom);
        if (m_phase == 2 && $urandom_range(0, 19) == 0) layer_go = 1'b1;
      end
      cyc();
      layer_go = 1'b0;
      n++;
    end
    chk("layer_bound", 32'(n < 3000), 32'd1);
    chk("pops", 32'(pops), 32'd150);
  endtask

  task automatic rand_dones(input int lo, input int hi);
    for (int i = 0; i < NCH; i++) done_t[i] = $urandom_range(lo, hi);
  endtask

  initial begin
    int n;
    int j;
    int tmp;
    rst         = 1'b1;
    layer_go    = 1'b0;
    layer_sel   = 1'b0;
    wfifo_level = '0;
    conv_done   = '0;
    pops        = 0;
    gap         = 0;
    seen_start  = 1'b0;
    for (int i = 0; i < NCH; i++) done_t[i] = -1;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // 28x28 layer, level parked at 149 first, staggered dones from cycle 829
    for (int i = 0; i < NCH; i++) done_t[i] = 829 + i;
    for (int i = NCH - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = done_t[i]; done_t[i] = done_t[j]; done_t[j] = tmp;
    end
    run_layer(1'b0, 12, 1'b0);
    repeat (3) cyc();

    // 12x12 layer with layer_sel wiggling and stray layer_go pulses in flight
    rand_dones(160, 900);
    run_layer(1'b1, $urandom_range(0, 5), 1'b1);
    repeat (2) cyc();

    // asynchronous reset at start-relative cycle 40 of LOAD, then a clean layer
    for (int i = 0; i < NCH; i++) done_t[i] = -1;
    wfifo_level = 8'd200;
    layer_sel   = 1'($urandom);
    layer_go    = 1'b1;
    cyc();
    layer_go = 1'b0;
    n = 0;
    while (!(m_phase == 2 && m_k == 40) && n < 100) begin cyc(); n++; end
    chk("reach_load40", 32'(n < 100), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(dut_outs()), 32'd0);
    model_reset();
    conv_done = '0;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    rand_dones(151, 700);
    run_layer(1'b0, 2, 1'b0);

    // engine 3 silent: timeout, then err_tmo holds while idle
    rand_dones(200, 600);
    done_t[3] = -1;
    run_layer(1'($urandom), 0, 1'b0);
    repeat (5) cyc();

    // final done on the timeout cycle: completion wins
    rand_dones(150, 600);
    done_t[3] = NW + TMO_C - 1;
    run_layer(1'($urandom), 1, 1'b0);

    // back-to-back go right after layer_done; all dones land during LOAD
    rand_dones(0, 149);
    run_layer(1'($urandom), 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      rand_dones(100, 1100);
      if ($urandom_range(0, 2) == 0) done_t[$urandom_range(0, NCH - 1)] = -1;
      run_layer(1'($urandom), $urandom_range(0, 4), 1'b1);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
